// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared definitions for the Pong video timing chain.
//   - Default horizontal/vertical timing constants (counts per line, lines
//     per frame, blank and sync window edges).
//   - count_t: the 9-bit count type used by both axes.
//   - inWindow(): half-open window compare, lo <= x < hi.
package video_timing_pkg;

    localparam int unsigned CNT_W     = 9;
    localparam int unsigned MAX_TOTAL = 512;

    localparam int unsigned DEF_H_TOTAL      = 455;
    localparam int unsigned DEF_V_TOTAL      = 262;
    localparam int unsigned DEF_H_BLANK_END  = 80;
    localparam int unsigned DEF_H_SYNC_START = 32;
    localparam int unsigned DEF_H_SYNC_END   = 64;
    localparam int unsigned DEF_V_BLANK_END  = 16;
    localparam int unsigned DEF_V_SYNC_START = 4;
    localparam int unsigned DEF_V_SYNC_END   = 8;

    typedef logic [CNT_W-1:0] count_t;

    function automatic logic inWindow(input count_t x, input count_t lo, input count_t hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// timing_axis
// One axis of the video timing: a wrapping counter, a registered start
// strobe that marks the wrap, a registered blank flag, and an active-low
// sync decode.
// Ports:
//   clk_i    - clock, all state changes on its rising edge
//   rst_ni   - synchronous active-low reset, overrides adv_i
//   adv_i    - advance enable for this axis
//   cnt_o    - current count (registered)
//   last_o   - count is at TOTAL-1 (decode of the register only)
//   start_o  - one-cycle pulse in the cycle the count first reads 0 after a wrap
//   blank_o  - high for counts 0..BLANK_END-1 (registered)
//   sync_no  - low while blanking and SYNC_START <= count < SYNC_END
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = DEF_H_TOTAL,
    parameter int unsigned BLANK_END  = DEF_H_BLANK_END,
    parameter int unsigned SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned SYNC_END   = DEF_H_SYNC_END
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             start_o,
    output logic             blank_o,
    output logic             sync_no
);

    // The counter is only 9 bits wide, so the total must fit and every
    // window edge must lie inside the count range.
    if (TOTAL > MAX_TOTAL || TOTAL < 2 || BLANK_END >= TOTAL ||
        SYNC_START >= TOTAL || SYNC_END >= TOTAL) begin : g_bad_params
        $error("timing_axis: timing parameters out of range for a 9-bit counter");
    end

    count_t cnt_q, cnt_d;
    logic   blank_q, blank_d;
    logic   start_q, start_d;

    assign last_o = (cnt_q == count_t'(TOTAL - 1));

    // Next-state: wrap at the last count, otherwise increment. The blank
    // flag sets on the wrap and clears as the count steps onto BLANK_END.
    // The start strobe is only raised on an advancing wrap, so it drops to
    // zero on any cycle where the axis does not advance.
    always_comb begin
        cnt_d   = cnt_q;
        blank_d = blank_q;
        start_d = 1'b0;
        if (adv_i) begin
            if (last_o) begin
                cnt_d   = '0;
                blank_d = 1'b1;
                start_d = 1'b1;
            end else begin
                cnt_d = cnt_q + count_t'(1);
                if (cnt_d == count_t'(BLANK_END)) begin
                    blank_d = 1'b0;
                end
            end
        end
    end

    // State register with synchronous reset to the start of blanking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            blank_q <= 1'b1;
            start_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            start_q <= start_d;
        end
    end

    // Sync is qualified by blank so it can never fire in the visible area.
    assign sync_no = ~(blank_q & inWindow(cnt_q, count_t'(SYNC_START), count_t'(SYNC_END)));
    assign cnt_o   = cnt_q;
    assign start_o = start_q;
    assign blank_o = blank_q;

endmodule

// File: rtl/video_timing.sv
// video_timing
// Registered horizontal/vertical timing sequencer for the Pong video chain.
// Ports:
//   mclk        - master clock
//   _reset      - synchronous active-low reset, overrides ce
//   ce          - pixel clock-enable
//   hcnt, vcnt  - 9-bit horizontal / vertical counts (registered)
//   _hreset     - low while hcnt is at its last count
//   _vreset     - low while both counts are at their last count
//   hblank/_hblank, vblank/_vblank - blank flags (registered) and inverses
//   _hsync, _vsync - active-low sync decodes
//   line_start, frame_start - one-cycle strobes when hcnt / both counts wrap
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned H_BLANK_END  = DEF_H_BLANK_END,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
    parameter int unsigned V_BLANK_END  = DEF_V_BLANK_END,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END
) (
    input  logic             mclk,
    input  logic             _reset,
    input  logic             ce,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             _hreset,
    output logic             _vreset,
    output logic             hblank,
    output logic             _hblank,
    output logic             _hsync,
    output logic             vblank,
    output logic             _vblank,
    output logic             _vsync,
    output logic             line_start,
    output logic             frame_start
);

    logic hLast;
    logic vLast;
    logic vAdvance;

    // The vertical axis steps once per line, on the ce cycle where the
    // horizontal count wraps.
    assign vAdvance = ce & hLast;

    timing_axis #(
        .TOTAL      (H_TOTAL),
        .BLANK_END  (H_BLANK_END),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END)
    ) uHorizontal (
        .clk_i   (mclk),
        .rst_ni  (_reset),
        .adv_i   (ce),
        .cnt_o   (hcnt),
        .last_o  (hLast),
        .start_o (line_start),
        .blank_o (hblank),
        .sync_no (_hsync)
    );

    timing_axis #(
        .TOTAL      (V_TOTAL),
        .BLANK_END  (V_BLANK_END),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END)
    ) uVertical (
        .clk_i   (mclk),
        .rst_ni  (_reset),
        .adv_i   (vAdvance),
        .cnt_o   (vcnt),
        .last_o  (vLast),
        .start_o (frame_start),
        .blank_o (vblank),
        .sync_no (_vsync)
    );

    // Reset strobes decode only registered counts, so they cannot glitch.
    assign _hreset = ~hLast;
    assign _vreset = ~(vLast & hLast);
    assign _hblank = ~hblank;
    assign _vblank = ~vblank;

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing
// Directed bench for video_timing. dutA runs the default timing; dutB is a
// shrunken 10x4 configuration used for whole-frame behaviour.
module tb_video_timing;

   logic mclk;
   logic nResetA, ceA;
   logic nResetB, ceB;

   logic [8:0] hcntA, vcntA, hcntB, vcntB;
   logic hResetNA, vResetNA, hblankA, hblankNA, hsyncNA, vblankA, vblankNA, vsyncNA, lineStartA, frameStartA;
   logic hResetNB, vResetNB, hblankB, hblankNB, hsyncNB, vblankB, vblankNB, vsyncNB, lineStartB, frameStartB;

   int testCount = 0;
   int failCount = 0;

   video_timing dutA (
      .mclk(mclk), ._reset(nResetA), .ce(ceA),
      .hcnt(hcntA), .vcnt(vcntA), ._hreset(hResetNA), ._vreset(vResetNA),
      .hblank(hblankA), ._hblank(hblankNA), ._hsync(hsyncNA),
      .vblank(vblankA), ._vblank(vblankNA), ._vsync(vsyncNA),
      .line_start(lineStartA), .frame_start(frameStartA)
   );

   video_timing #(
      .H_TOTAL(10), .V_TOTAL(4), .H_BLANK_END(3), .V_BLANK_END(1),
      .H_SYNC_START(1), .H_SYNC_END(2), .V_SYNC_START(0), .V_SYNC_END(1)
   ) dutB (
      .mclk(mclk), ._reset(nResetB), .ce(ceB),
      .hcnt(hcntB), .vcnt(vcntB), ._hreset(hResetNB), ._vreset(vResetNB),
      .hblank(hblankB), ._hblank(hblankNB), ._hsync(hsyncNB),
      .vblank(vblankB), ._vblank(vblankNB), ._vsync(vsyncNB),
      .line_start(lineStartB), .frame_start(frameStartB)
   );

   // Free-running master clock.
   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just past the edge before sampling.
   task automatic applyStimulus();
      @(posedge mclk);
      #1;
   endtask

   initial begin
      int hblankCnt, hsyncLowCnt, hsyncBad, hresetLowCnt, hresetAt, vresetLowCnt;
      int lineCnt, hcntErr, holdErr, strobeErr, ceCount, budget;
      int vblankLines, vsyncLines;
      int bLine, bFrame, bFrameAt, bHblank, bVblank, bVreset, bVsync, bHsync, bBoth;
      logic [8:0] prevH, prevV;
      logic prevHb, prevVb;

      nResetA = 1'b0; ceA = 1'b1;
      nResetB = 1'b0; ceB = 1'b1;
      repeat (3) applyStimulus();

      // Reset state with ce held high.
      checkOutput("rst_hcnt", hcntA, 0);
      checkOutput("rst_vcnt", vcntA, 0);
      checkOutput("rst_hblank", hblankA, 1);
      checkOutput("rst_nhblank", hblankNA, 0);
      checkOutput("rst_vblank", vblankA, 1);
      checkOutput("rst_nvblank", vblankNA, 0);
      checkOutput("rst_hreset", hResetNA, 1);
      checkOutput("rst_vreset", vResetNA, 1);
      checkOutput("rst_hsync", hsyncNA, 1);
      checkOutput("rst_vsync", vsyncNA, 1);
      checkOutput("rst_line", lineStartA, 0);
      checkOutput("rst_frame", frameStartA, 0);

      // One full line of default timing.
      nResetA = 1'b1;
      hblankCnt = 0; hsyncLowCnt = 0; hsyncBad = 0; hresetLowCnt = 0;
      hresetAt = -1; vresetLowCnt = 0; lineCnt = 0; hcntErr = 0;
      for (int i = 0; i < 455; i++) begin
         if (hcntA != 9'(i)) hcntErr++;
         if (hblankA) hblankCnt++;
         if (!hsyncNA) hsyncLowCnt++;
         if ((!hsyncNA) != (i >= 32 && i < 64)) hsyncBad++;
         if (!hResetNA) begin hresetLowCnt++; hresetAt = i; end
         if (!vResetNA) vresetLowCnt++;
         if (lineStartA) lineCnt++;
         applyStimulus();
      end
      checkOutput("line_hcnt_seq", hcntErr, 0);
      checkOutput("line_hblank_width", hblankCnt, 80);
      checkOutput("line_hsync_width", hsyncLowCnt, 32);
      checkOutput("line_hsync_place", hsyncBad, 0);
      checkOutput("line_hreset_count", hresetLowCnt, 1);
      checkOutput("line_hreset_at", hresetAt, 454);
      checkOutput("line_vreset_none", vresetLowCnt, 0);
      checkOutput("line_no_early_strobe", lineCnt, 0);
      checkOutput("wrap_hcnt", hcntA, 0);
      checkOutput("wrap_vcnt", vcntA, 1);
      checkOutput("wrap_line_start", lineStartA, 1);
      checkOutput("wrap_frame_start", frameStartA, 0);
      checkOutput("wrap_hblank", hblankA, 1);

      // Random ce at 30% density: hold while low, totals follow gated count.
      holdErr = 0; strobeErr = 0; ceCount = 0;
      for (int i = 0; i < 300; i++) begin
         ceA = ($urandom_range(0, 9) < 3);
         prevH = hcntA; prevV = vcntA; prevHb = hblankA; prevVb = vblankA;
         if (ceA) ceCount++;
         applyStimulus();
         if (!ceA && (hcntA != prevH || vcntA != prevV || hblankA != prevHb || vblankA != prevVb)) holdErr++;
         if (lineStartA || frameStartA) strobeErr++;
      end
      checkOutput("ce_hold", holdErr, 0);
      checkOutput("ce_no_strobe", strobeErr, 0);
      checkOutput("ce_hcnt_total", hcntA, ceCount);
      checkOutput("ce_vcnt_total", vcntA, 1);

      // Run to hcnt=200, vcnt=100, watching vertical blank/sync per line.
      ceA = 1'b1;
      budget = 0; vblankLines = 0; vsyncLines = 0;
      while (!(hcntA == 9'd200 && vcntA == 9'd100) && budget < 50000) begin
         applyStimulus();
         budget++;
         if (hcntA == 9'd0) begin
            if (vblankA) vblankLines++;
            if (!vsyncNA) vsyncLines++;
         end
      end
      checkOutput("reach_200_100", budget < 50000, 1);
      checkOutput("vblank_lines_2_to_100", vblankLines, 14);
      checkOutput("vsync_lines", vsyncLines, 4);

      // Mid-frame reset with ce high.
      nResetA = 1'b0;
      applyStimulus();
      checkOutput("midrst_hcnt", hcntA, 0);
      checkOutput("midrst_vcnt", vcntA, 0);
      checkOutput("midrst_hblank", hblankA, 1);
      checkOutput("midrst_vblank", vblankA, 1);
      checkOutput("midrst_line", lineStartA, 0);
      checkOutput("midrst_frame", frameStartA, 0);
      nResetA = 1'b1;

      // Small configuration: one 40-cycle frame.
      nResetB = 1'b1;
      bLine = 0; bFrame = 0; bFrameAt = -1; bHblank = 0; bVblank = 0;
      bVreset = 0; bVsync = 0; bHsync = 0; bBoth = 0;
      for (int j = 1; j <= 40; j++) begin
         if (!vResetNB) bVreset++;
         applyStimulus();
         if (lineStartB) bLine++;
         if (frameStartB) begin bFrame++; bFrameAt = j; end
         if (lineStartB && frameStartB) bBoth++;
         if (hblankB) bHblank++;
         if (vblankB) bVblank++;
         if (!vsyncNB) bVsync++;
         if (!hsyncNB) bHsync++;
      end
      checkOutput("small_frame_len", bFrameAt, 40);
      checkOutput("small_frame_count", bFrame, 1);
      checkOutput("small_line_count", bLine, 4);
      checkOutput("small_both_strobes", bBoth, 1);
      checkOutput("small_hblank_cycles", bHblank, 12);
      checkOutput("small_vblank_cycles", bVblank, 10);
      checkOutput("small_vsync_cycles", bVsync, 10);
      checkOutput("small_hsync_cycles", bHsync, 4);
      checkOutput("small_vreset_cycles", bVreset, 1);
      checkOutput("small_end_hcnt", hcntB, 0);
      checkOutput("small_end_vcnt", vcntB, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
